mem_burst_master: RTL and testbench
===================================

# mem_burst_master

Burst initiator for the single-port synchronous memory `mem_d`. It accepts one command at a time: direction, base address and beat count. It then drives the memory's valid/read-write/address/write-data port one beat per cycle.
- Write data is taken from a valid/ready stream.
- Read data is returned on a valid/ready stream with backpressure. The memory's registered, value-holding `rd_data` serves as the output holding register, so read throughput is one beat per cycle.

## Interface
- DATA_WIDTH, 32, data word width; matches memory.
- ADDR_WIDTH, 16, word address width; matches memory.
- LEN_WIDTH, 8, command length field width.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_wr  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_WIDTH  base word address.
- cmd_len  in  LEN_WIDTH  beats minus one (0 → 1 beat, max 2^LEN_WIDTH beats).
- wdata_valid  in  1  write beat offered.
- wdata_ready  out  1  write beat accepted.
- wdata  in  DATA_WIDTH  write beat.
- rdata_valid  out  1  read beat available.
- rdata_ready  in  1  read beat consumed.
- rdata  out  DATA_WIDTH  read beat; equals mem_rd_data.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at burst completion.
- mem_valid  out  1  to memory rd_wr_valid.
- mem_rd_wr  out  1  to memory rd_wr_mem (1 = write).
- mem_addr  out  ADDR_WIDTH  to memory mem_addr.
- mem_wr_data  out  DATA_WIDTH  to memory wr_data.
- mem_rd_data  in  DATA_WIDTH  from memory rd_data.

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE:
  - cmd_ready=1.
  - cmd_valid&&cmd_ready captures addr_q=cmd_addr, cnt_q=cmd_len, dir.
  - Next state is WRITE or READ.
- WRITE:
  - wdata_ready=1.
  - mem_valid=wdata_valid, mem_rd_wr=1, mem_addr=addr_q, mem_wr_data=wdata.
  - Each accepted beat: addr_q+1, cnt_q-1.
  - Beat accepted with cnt_q==0 → DONE.
- READ:
  - issue = !rdata_valid || rdata_ready.
  - mem_valid=issue, mem_rd_wr=0, mem_addr=addr_q.
  - Each issue: addr_q+1, cnt_q-1.
  - Issue with cnt_q==0 → DRAIN.
- rdata_valid register:
  - Set on issue.
  - Else cleared on rdata_ready.
  - Else held.
- DRAIN: rdata_valid&&rdata_ready → DONE.
- DONE: done=1 for one cycle → IDLE. cmd_ready=0 in DONE.
- Memory-side outputs are combinational from registered state and stream inputs.
  - mem_valid=0 in IDLE, DRAIN and DONE.
  - mem_wr_data=wdata in all states; it is ignored when mem_rd_wr=0.
- Address arithmetic is modulo 2^ADDR_WIDTH: 0xFFFF+1 → 0x0000, with no error.
- cnt_q underflow is impossible; the transition happens at cnt_q==0.
- The block never issues a read while the previous read beat is unconsumed, except in the same cycle it is consumed.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, addr_q=0, cnt_q=0, rdata_valid=0, done=0, busy=0.
  - cmd_ready=1, wdata_ready=0, mem_valid=0, mem_rd_wr=0, mem_addr=0.
- Command accept at edge t → first memory beat possible in cycle t+1.
- Write: beat handshake in cycle t → memory writes at edge ending cycle t.
  - N beats with wdata_valid held high → done pulse in cycle t0+N+1, where t0 is the accept cycle.
- Read: issue in cycle t → mem_rd_data updates at the edge → rdata_valid=1 in cycle t+1.
  - rdata_ready held high → one beat per cycle.
  - done asserts the cycle after the last beat is consumed.
- Back-to-back commands: next cmd accepted no earlier than the cycle after DONE.
- Reset mid-burst: abort immediately, nothing further is written, pending rdata is discarded, no done pulse.
- wdata_valid low in WRITE → mem_valid=0 and counters hold.
- rdata_ready low → no new issue; rdata is stable because the memory holds rd_data.

## Structure
- Shared package `mem_pkg`: state enum `burst_state_e` (IDLE, WRITE, READ, DRAIN, DONE), DATA_WIDTH/ADDR_WIDTH defaults.
- Single module, no sub-module.
- The bench instantiates mem_burst_master connected to `mem_d` with matching parameters.

## Test plan
- Reset: rst_n=0 → cmd_ready=1, mem_valid=0, rdata_valid=0, busy=0, done=0.
- Write burst: addr=0x0010, len=3, wdata 0xA0..0xA3, wdata_valid always high → mem addresses 0x10..0x13 on consecutive cycles; done 5 cycles after accept; memory holds the values.
- Read burst with backpressure: read back 0x10, len=3, rdata_ready toggling 1,0,1,0… → rdata sequence 0xA0..0xA3 with no loss or duplication; rdata stable while ready=0; done after the 4th consumption.
- Wrap-around: write addr=0xFFFE, len=3 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001; read back matches.
- Write stall: wdata_valid low for 3 cycles mid-burst → mem_valid low and addr held for those cycles; burst completes with correct data.
- Reset mid-read: assert rst_n=0 after 2 of 8 beats → immediate IDLE, rdata_valid=0, no done; a subsequent 1-beat read (len=0) returns the correct word.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the mem_d burst initiator and its memory.
//   burst_state_e : burst sequencer states
//   MEM_*_WIDTH   : default data / address / length field widths
package mem_pkg;
  localparam int MEM_DATA_WIDTH = 32;
  localparam int MEM_ADDR_WIDTH = 16;
  localparam int MEM_LEN_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } burst_state_e;
endpackage

// File: rtl/mem_burst_master_if.sv
// Bus bundle for mem_burst_master: command, write stream, read stream,
// status and the mem_d memory port.
//   master : the burst initiator side
//   slave  : the environment (command source, streams, memory)
interface mem_burst_master_if
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = MEM_LEN_WIDTH
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_wr;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  wdata_valid;
  logic                  wdata_ready;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rdata_valid;
  logic                  rdata_ready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  busy;
  logic                  done;
  logic                  mem_valid;
  logic                  mem_rd_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata_valid, wdata,
           rdata_ready, mem_rd_data,
    output cmd_ready, wdata_ready, rdata_valid, rdata, busy, done,
           mem_valid, mem_rd_wr, mem_addr, mem_wr_data
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_len, wdata_valid, wdata,
           rdata_ready, mem_rd_data,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, busy, done,
           mem_valid, mem_rd_wr, mem_addr, mem_wr_data
  );
endinterface

// File: rtl/mem_d.sv
// Single-port synchronous memory. One access per cycle when rd_wr_valid:
// write (rd_wr_mem=1) stores wr_data; read registers the word into rd_data,
// which then holds until the next read.
//   clk, rd_wr_valid, rd_wr_mem, mem_addr, wr_data -> in
//   rd_data -> out (registered, value-holding)
module mem_d
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rd_wr_valid,
  input  logic                  rd_wr_mem,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (rd_wr_valid) begin
      if (rd_wr_mem) mem[mem_addr] <= wr_data;
      else           rd_data       <= mem[mem_addr];
    end
  end
endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for mem_d. Takes one command (direction, base address,
// beats-1), then drives one memory beat per cycle. Write beats come from
// the wdata stream; read beats leave on the rdata stream, using the
// memory's held rd_data as the output register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command / wdata / rdata streams, busy, done, memory port
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int LEN_WIDTH  = MEM_LEN_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_burst_master_if.master bus
);
  burst_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  rvld_q;
  logic                  accept, wr_beat, issue, step, last;

  // A read may only be issued when the held rd_data is free or being
  // consumed this cycle, otherwise the memory would overwrite it.
  always_comb begin
    accept  = (state_q == IDLE) && bus.cmd_valid;
    wr_beat = (state_q == WRITE) && bus.wdata_valid;
    issue   = (state_q == READ) && (!rvld_q || bus.rdata_ready);
    step    = wr_beat || issue;
    last    = (cnt_q == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cmd_valid) state_d = bus.cmd_wr ? WRITE : READ;
      WRITE:   if (wr_beat && last) state_d = DONE;
      READ:    if (issue && last) state_d = DRAIN;
      DRAIN:   if (rvld_q && bus.rdata_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      rvld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= bus.cmd_addr;
        cnt_q  <= bus.cmd_len;
      end else if (step) begin
        // Address wraps naturally; count stops at zero on the final beat.
        addr_q <= addr_q + 1'b1;
        if (!last) cnt_q <= cnt_q - 1'b1;
      end
      if (issue)                rvld_q <= 1'b1;
      else if (bus.rdata_ready) rvld_q <= 1'b0;
    end
  end

  assign bus.cmd_ready   = (state_q == IDLE);
  assign bus.wdata_ready = (state_q == WRITE);
  assign bus.rdata_valid = rvld_q;
  assign bus.rdata       = bus.mem_rd_data;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = (state_q == DONE);
  assign bus.mem_valid   = step;
  assign bus.mem_rd_wr   = (state_q == WRITE);
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wr_data = bus.wdata;
endmodule

// File: tb/tb_mem_burst_master.sv
module tb_mem_burst_master;
  import mem_pkg::*;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  mem_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  mem_d #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_mem (
    .clk(clk), .rd_wr_valid(bus.mem_valid), .rd_wr_mem(bus.mem_rd_wr),
    .mem_addr(bus.mem_addr), .wr_data(bus.mem_wr_data), .rd_data(bus.mem_rd_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_q [$];

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 0; bus.cmd_wr = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wdata_valid = 0; bus.wdata = '0; bus.rdata_ready = 0;
    #2;
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready); end
    n_tests++; if (bus.mem_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_valid got %b exp 0", bus.mem_valid); end
    n_tests++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rdata_valid got %b exp 0", bus.rdata_valid); end
    n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b%b exp 00", bus.busy, bus.done); end
    n_tests++; if (bus.wdata_ready !== 1'b0 || bus.mem_rd_wr !== 1'b0 || bus.mem_addr !== '0) begin
      n_fail++; $display("FAIL reset_mem_port got wr_rdy=%b rd_wr=%b addr=%h exp 0,0,0000", bus.wdata_ready, bus.mem_rd_wr, bus.mem_addr); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Write burst; the beat with index stall_at is withheld for stall_n cycles.
  task automatic run_write(input logic [AW-1:0] a, input int len, input logic [DW-1:0] d0,
                           input int stall_at, input int stall_n, input string tag);
    int beat = 0, stalled = 0, cyc = 0;
    logic stall;
    logic [AW-1:0] ea;
    @(posedge clk); #1;
    bus.cmd_valid = 1; bus.cmd_wr = 1; bus.cmd_addr = a; bus.cmd_len = LW'(len); bus.wdata_valid = 0;
    @(negedge clk);
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s_cmd_ready got %b exp 1", tag, bus.cmd_ready); end
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    while (beat <= len && cyc < 300) begin
      stall = (beat == stall_at) && (stalled < stall_n);
      ea = a + AW'(beat);
      bus.wdata_valid = !stall;
      bus.wdata = d0 + DW'(beat);
      @(negedge clk);
      n_tests++; if (bus.mem_valid !== !stall) begin n_fail++; $display("FAIL %s_mem_valid beat %0d got %b exp %b", tag, beat, bus.mem_valid, !stall); end
      n_tests++; if (bus.mem_addr !== ea) begin n_fail++; $display("FAIL %s_mem_addr beat %0d got %h exp %h", tag, beat, bus.mem_addr, ea); end
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s_early_done beat %0d got %b exp 0", tag, beat, bus.done); end
      if (!stall) begin
        n_tests++; if (bus.mem_rd_wr !== 1'b1 || bus.mem_wr_data !== d0 + DW'(beat)) begin
          n_fail++; $display("FAIL %s_wr_beat %0d got rd_wr=%b data=%h exp 1 %h", tag, beat, bus.mem_rd_wr, bus.mem_wr_data, d0 + DW'(beat)); end
        model_mem[ea] = d0 + DW'(beat);
        beat++;
      end else stalled++;
      cyc++;
      @(posedge clk); #1;
    end
    bus.wdata_valid = 0;
    n_tests++; if (cyc >= 300) begin n_fail++; $display("FAIL %s_timeout beats %0d exp %0d", tag, beat, len + 1); end
    @(negedge clk);
    n_tests++; if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s_done got done=%b cmd_ready=%b exp 1 0", tag, bus.done, bus.cmd_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    n_tests++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_idle got done=%b cmd_ready=%b exp 0 1", tag, bus.done, bus.cmd_ready); end
  endtask

  // Read burst; expected words are queued at command time from the model.
  // abort_after>0 asserts reset right after that many beats are consumed.
  task automatic run_read(input logic [AW-1:0] a, input int len, input bit toggle,
                          input int abort_after, input string tag);
    int issued = 0, consumed = 0, cyc = 0;
    bit aborted = 0, hold = 0;
    logic [DW-1:0] held, want;
    logic [AW-1:0] ea;
    for (int i = 0; i <= len; i++) exp_q.push_back(model_mem[a + AW'(i)]);
    @(posedge clk); #1;
    bus.cmd_valid = 1; bus.cmd_wr = 0; bus.cmd_addr = a; bus.cmd_len = LW'(len);
    @(negedge clk);
    n_tests++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL %s_cmd_ready got %b exp 1", tag, bus.cmd_ready); end
    @(posedge clk); #1;
    bus.cmd_valid = 0;
    while (consumed <= len && cyc < 300 && !aborted) begin
      bus.rdata_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (bus.mem_valid === 1'b1) begin
        ea = a + AW'(issued);
        n_tests++; if (bus.mem_rd_wr !== 1'b0 || bus.mem_addr !== ea) begin
          n_fail++; $display("FAIL %s_issue %0d got rd_wr=%b addr=%h exp 0 %h", tag, issued, bus.mem_rd_wr, bus.mem_addr, ea); end
        n_tests++; if (bus.rdata_valid === 1'b1 && bus.rdata_ready !== 1'b1) begin
          n_fail++; $display("FAIL %s_overrun issue %0d got rdata_valid=1 ready=0 exp no issue", tag, issued); end
        issued++;
      end
      if (hold) begin
        n_tests++; if (bus.rdata_valid !== 1'b1 || bus.rdata !== held) begin
          n_fail++; $display("FAIL %s_stable got v=%b d=%h exp 1 %h", tag, bus.rdata_valid, bus.rdata, held); end
      end
      n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL %s_early_done got 1 exp 0 at beat %0d", tag, consumed); end
      hold = bus.rdata_valid && !bus.rdata_ready;
      held = bus.rdata;
      if (bus.rdata_valid === 1'b1 && bus.rdata_ready === 1'b1) begin
        want = exp_q.pop_front();
        n_tests++; if (bus.rdata !== want) begin n_fail++; $display("FAIL %s_rdata beat %0d got %h exp %h", tag, consumed, bus.rdata, want); end
        consumed++;
      end
      cyc++;
      if (abort_after > 0 && consumed == abort_after) begin
        aborted = 1;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rdata_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin
          n_fail++; $display("FAIL %s_abort got busy=%b cmd_ready=%b rvld=%b mvld=%b exp 0 1 0 0",
                             tag, bus.busy, bus.cmd_ready, bus.rdata_valid, bus.mem_valid); end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          n_tests++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL %s_post_abort got done=%b busy=%b exp 0 0", tag, bus.done, bus.busy); end
        end
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!aborted) begin
      n_tests++; if (consumed != len + 1) begin n_fail++; $display("FAIL %s_timeout got %0d beats exp %0d", tag, consumed, len + 1); end
      n_tests++; if (issued != len + 1) begin n_fail++; $display("FAIL %s_issue_count got %0d exp %0d", tag, issued, len + 1); end
      @(negedge clk);
      n_tests++; if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL %s_done got done=%b cmd_ready=%b exp 1 0", tag, bus.done, bus.cmd_ready); end
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL %s_idle got done=%b cmd_ready=%b exp 0 1", tag, bus.done, bus.cmd_ready); end
    end
    bus.rdata_ready = 0;
  endtask

  task automatic test_write_burst();
    run_write(16'h0010, 3, 32'h0000_00A0, -1, 0, "wr");
  endtask

  task automatic test_read_backpressure();
    run_read(16'h0010, 3, 1'b1, 0, "rd_bp");
  endtask

  task automatic test_wrap();
    run_write(16'hFFFE, 3, 32'h0000_00C0, -1, 0, "wrap_wr");
    run_read(16'hFFFE, 3, 1'b0, 0, "wrap_rd");
  endtask

  task automatic test_write_stall();
    run_write(16'h0100, 5, 32'h0000_00B0, 2, 3, "stall_wr");
    run_read(16'h0100, 5, 1'b0, 0, "stall_rd");
  endtask

  task automatic test_reset_mid_read();
    run_write(16'h0200, 7, 32'h0000_00D0, -1, 0, "abort_wr");
    run_read(16'h0200, 7, 1'b0, 2, "abort_rd");
    run_read(16'h0205, 0, 1'b0, 0, "single_rd");
  endtask

  task automatic test_back_to_back();
    run_read(16'h0010, 0, 1'b0, 0, "b2b_rd0");
    run_read(16'h0013, 1, 1'b1, 0, "b2b_rd1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_burst();
    test_read_backpressure();
    test_wrap();
    test_write_stall();
    test_reset_mid_read();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
